echo_delay_ctrl: RTL
====================

ECHO_DELAY_CTRL -- requirements
Module: echo_delay_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, sample data width.
REQ-002 SHALL have parameter AW, default 13, FIFO address width; DEPTH = 2^AW.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable  input  1  run request, level.
REQ-006 SHALL have port in_valid  input  1  one-cycle sample strobe.
REQ-007 SHALL have port in_data  input  DW  input sample.
REQ-008 SHALL have port delay_num  input  AW  requested delay in samples.
REQ-009 SHALL have port delay_load  input  1  one-cycle pulse, apply delay_num.
REQ-010 SHALL have port fifo_wr_en  output  1  external FIFO write enable.
REQ-011 SHALL have port fifo_wr_data  output  DW  external FIFO write data.
REQ-012 SHALL have port fifo_rd_en  output  1  external FIFO read enable.
REQ-013 SHALL have port fifo_flush  output  1  external FIFO synchronous clear.
REQ-014 SHALL have port fifo_q  input  DW  FIFO read data, valid 1 cycle after fifo_rd_en.
REQ-015 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-016 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-017 SHALL have port out_valid  output  1  one-cycle output sample strobe.
REQ-018 SHALL have port out_data  output  DW  delayed sample.
REQ-019 SHALL have port state  output  2  FSM state: IDLE=0, FLUSH=1, FILL=2, RUN=3.
REQ-020 SHALL have port overflow  output  1  sticky: write attempted with fifo_full.
REQ-021 SHALL have port underrun  output  1  sticky: read needed with fifo_empty.

Function
REQ-022 SHALL, in IDLE, drive fifo_wr_en, fifo_rd_en, fifo_flush, out_valid low; enable=1 -> FLUSH next cycle.
REQ-023 SHALL, in FLUSH (exactly one cycle), assert fifo_flush, clear fill counter, latch target = clamp(delay_num, 1, DEPTH-1), -> FILL.
REQ-024 SHALL, in FILL on in_valid: fifo_wr_en=1, fifo_wr_data=in_data, fill counter +1, no read; out_valid=1 with out_data=0 on next cycle.
REQ-025 SHALL transition FILL -> RUN on the cycle after the write that makes fill counter equal target.
REQ-026 SHALL, in RUN on in_valid: fifo_wr_en=1 and fifo_rd_en=1 same cycle; out_valid=1 with out_data=fifo_q next cycle (latency 1 cycle); occupancy held at target.
REQ-027 SHALL hold out_data at last value when out_valid=0.
REQ-028 SHALL, on delay_load in FILL or RUN, go to FLUSH next cycle; in_valid in that cycle is processed normally first.
REQ-029 SHALL, on delay_load in IDLE, ignore it; target is latched only in FLUSH.
REQ-030 SHALL, on enable=0 in any state, go to IDLE next cycle; enable has priority over delay_load.
REQ-031 SHALL, when a write is due and fifo_full=1, suppress fifo_wr_en and set overflow.
REQ-032 SHALL, when a RUN read is due and fifo_empty=1, suppress fifo_rd_en, set underrun, emit out_valid with out_data=0.
REQ-033 SHALL clear overflow and underrun only on reset or in FLUSH.
REQ-034 SHALL size fill counter AW bits; no wrap possible since target <= DEPTH-1.

Reset
REQ-035 SHALL, while reset=1, force state=IDLE, all outputs 0, counter and target 0, regardless of in-flight samples.
REQ-036 SHALL resume from IDLE on first clock with reset=0; no fifo_flush issued by reset itself (FLUSH precedes any write).

Verification
REQ-037 Reset mid-RUN with in_valid=1 -> next cycle state=0, fifo_wr_en=0, out_valid=0, overflow=0.
REQ-038 delay_num=4, enable=1, samples 1..10 every 4 cycles -> FLUSH 1 cycle, outputs 0,0,0,0,1,2,3,4,5,6.
REQ-039 delay_num=0 -> target 1; samples 7,8,9 -> outputs 0,7,8.
REQ-040 delay_num=8191 (AW=13) -> 8191 zero outputs, then first input sample; fifo_full never seen, overflow=0.
REQ-041 In RUN (target 4), delay_load with delay_num=2 -> FLUSH, fifo_flush 1 cycle, then outputs 0,0, then post-load samples.
REQ-042 Force fifo_empty=1 in RUN -> fifo_rd_en=0, out_data=0, underrun=1 until next FLUSH; fifo_full=1 during write -> overflow=1.

Source files
------------

// File: rtl/echo_delay_ctrl.sv
// rtl/echo_delay_ctrl.sv - echo delay line controller driving an external sample FIFO
// The FIFO holds exactly `target` samples in RUN, so every read returns the sample written target inputs ago.
module echo_delay_ctrl #(
  parameter int DW = 16,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] delay_num,
  input  logic          delay_load,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_wr_data,
  output logic          fifo_rd_en,
  output logic          fifo_flush,
  input  logic [DW-1:0] fifo_q,
  input  logic          fifo_empty,
  input  logic          fifo_full,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    state,
  output logic          overflow,
  output logic          underrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_FILL  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [AW-1:0] target_q, target_d;
  logic          ovf_q, ovf_d;
  logic          und_q, und_d;
  logic          pend_q, pend_d;
  logic          src_q, src_d;
  logic [DW-1:0] hold_q, hold_d;

  logic          wr_c, rd_c, flush_c, sample_c;
  logic [AW-1:0] fill_inc;
  logic [DW-1:0] out_data_c;

  assign sample_c = in_valid && enable;
  assign fill_inc = fill_q + {{(AW-1){1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    target_d = target_q;
    ovf_d    = ovf_q;
    und_d    = und_q;
    pend_d   = 1'b0;
    src_d    = 1'b0;
    wr_c     = 1'b0;
    rd_c     = 1'b0;
    flush_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        flush_c  = 1'b1;
        fill_d   = '0;
        target_d = (delay_num == '0) ? {{(AW-1){1'b0}}, 1'b1} : delay_num;
        ovf_d    = 1'b0;
        und_d    = 1'b0;
        state_d  = S_FILL;
      end
      S_FILL: begin
        // Priming phase: every accepted sample is echoed as silence.
        if (sample_c) begin
          pend_d = 1'b1;
          fill_d = fill_inc;
          if (fifo_full) ovf_d = 1'b1;
          else           wr_c  = 1'b1;
          if (fill_inc == target_q) state_d = S_RUN;
        end
        if (delay_load) state_d = S_FLUSH;
      end
      S_RUN: begin
        if (sample_c) begin
          pend_d = 1'b1;
          if (fifo_full) ovf_d = 1'b1;
          else           wr_c  = 1'b1;
          if (fifo_empty) und_d = 1'b1;
          else begin
            rd_c  = 1'b1;
            src_d = 1'b1;
          end
        end
        if (delay_load) state_d = S_FLUSH;
      end
      default: state_d = S_IDLE;
    endcase
    if (!enable) state_d = S_IDLE;
  end

  // fifo_q is only valid the cycle after the read, so the output is muxed live and held afterwards.
  assign out_data_c = pend_q ? (src_q ? fifo_q : '0) : hold_q;
  assign hold_d     = out_data_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      fill_q   <= '0;
      target_q <= '0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
      pend_q   <= 1'b0;
      src_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      target_q <= target_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
      pend_q   <= pend_d;
      src_q    <= src_d;
      hold_q   <= hold_d;
    end
  end

  assign fifo_wr_en   = wr_c && !reset;
  assign fifo_wr_data = reset ? '0 : in_data;
  assign fifo_rd_en   = rd_c && !reset;
  assign fifo_flush   = flush_c && !reset;
  assign out_valid    = pend_q && !reset;
  assign out_data     = reset ? '0 : out_data_c;
  assign state        = reset ? 2'd0 : state_q;
  assign overflow     = ovf_q && !reset;
  assign underrun     = und_q && !reset;

endmodule
